// File: rtl/mem_ctr_pkg.sv
// Shared types and elaboration helpers for the parametrised main-memory controller.
// Command/response encodings match the cache-to-memory bus (bus 2).
package mem_ctr_pkg;

  typedef enum logic [1:0] {
    NOP        = 2'd0,
    RSVD       = 2'd1,
    READ_LINE  = 2'd2,
    WRITE_LINE = 2'd3
  } cmd_e;

  typedef enum logic {
    BUSY     = 1'b0,
    RESPONSE = 1'b1
  } resp_e;

  typedef logic [2:0] state_e;

  localparam state_e ST_IDLE     = 3'd0;
  localparam state_e ST_RD_WAIT  = 3'd1;
  localparam state_e ST_RD_BURST = 3'd2;
  localparam state_e ST_WR_BURST = 3'd3;
  localparam state_e ST_WR_WAIT  = 3'd4;
  localparam state_e ST_RESP     = 3'd5;

  // The write response must follow the last sampled beat; a read needs one BUSY cycle.
  function automatic bit lat_legal(input int unsigned read_lat, input int unsigned write_lat,
                                   input int unsigned burst);
    return (read_lat >= 2) && (write_lat >= burst + 1);
  endfunction

endpackage

// File: rtl/mem_ctr_array.sv
// Word-organised backing store: one synchronous write port, one asynchronous read port.
// No reset; contents survive controller resets.
module mem_ctr_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 131072,
  parameter int unsigned AW     = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctr_param.sv
// Whole-line main-memory controller on bus 2: FSM, beat/latency counters, sticky protocol
// error and saturating read/write statistics; the top level owns the D2/C2 tristates.
module mem_ctr_param
  import mem_ctr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MEM_BYTES  = 262144,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned READ_LAT   = 100,
  parameter int unsigned WRITE_LAT  = 100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A2,
  input  logic [DATA_W-1:0] D2_in,
  output logic [DATA_W-1:0] D2_out,
  output logic              D2_oe,
  input  logic [1:0]        C2_in,
  output logic [1:0]        C2_out,
  output logic              C2_oe,
  output logic              err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned BURST   = LINE_BYTES * 8 / DATA_W;
  localparam int unsigned DEPTH   = MEM_BYTES / (DATA_W / 8);
  localparam int unsigned WAW     = $clog2(DEPTH);
  localparam int unsigned LAT_MAX = (READ_LAT + BURST > WRITE_LAT + 1) ? READ_LAT + BURST
                                                                       : WRITE_LAT + 1;
  localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);
  localparam int unsigned BEAT_W  = $clog2(BURST + 1);

  if (!lat_legal(READ_LAT, WRITE_LAT, BURST)) begin : g_bad_lat
    $error("mem_ctr_param: READ_LAT must be >= 2 and WRITE_LAT >= BURST+1");
  end
  if ((DATA_W % 8 != 0) || (LINE_BYTES % (DATA_W / 8) != 0) ||
      (ADDR_W != $clog2(MEM_BYTES / LINE_BYTES))) begin : g_bad_geom
    $error("mem_ctr_param: inconsistent DATA_W/LINE_BYTES/MEM_BYTES/ADDR_W");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d, lat_inc;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    rd_cnt_q, wr_cnt_q;
  logic                rd_done, wr_done;
  cmd_e                cmd;
  resp_e               resp;
  logic                mem_we;
  logic [WAW-1:0]      mem_waddr, mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;

  function automatic logic [WAW-1:0] word_addr(input logic [ADDR_W-1:0] line,
                                               input logic [BEAT_W-1:0] beat);
    return WAW'(line) * WAW'(BURST) + WAW'(beat);
  endfunction

  assign cmd     = cmd_e'(C2_in);
  assign lat_inc = lat_q + LAT_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lat_d  = '0;
        beat_d = '0;
        if (cmd == READ_LINE) begin
          addr_d  = A2;
          state_d = ST_RD_WAIT;
        end else if (cmd == WRITE_LINE) begin
          // Beat 0 is written at the command edge itself.
          addr_d  = A2;
          beat_d  = BEAT_W'(1);
          state_d = (BURST == 1) ? ST_WR_WAIT : ST_WR_BURST;
        end
      end
      ST_RD_WAIT: begin
        lat_d = lat_inc;
        if (lat_inc == LAT_W'(READ_LAT)) begin
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        lat_d  = lat_inc;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BURST - 1)) begin
          state_d = ST_IDLE;
          rd_done = 1'b1;
        end
      end
      ST_WR_BURST: begin
        lat_d  = lat_inc;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BURST - 1)) begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        lat_d = lat_inc;
        if (lat_inc == LAT_W'(WRITE_LAT)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        wr_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commands arriving mid-transaction are dropped but flagged; RSVD counts as NOP.
  assign err_d = err_q | ((state_q != ST_IDLE) && ((cmd == READ_LINE) || (cmd == WRITE_LINE)));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      lat_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      if (rd_done && (rd_cnt_q != {CNT_W{1'b1}})) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (wr_done && (wr_cnt_q != {CNT_W{1'b1}})) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_we    = ((state_q == ST_IDLE) && (cmd == WRITE_LINE)) || (state_q == ST_WR_BURST);
  assign mem_waddr = (state_q == ST_IDLE) ? word_addr(A2, '0) : word_addr(addr_q, beat_q);
  assign mem_raddr = word_addr(addr_q, beat_q);

  mem_ctr_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (WAW)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (D2_in),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // The command-sample cycle (lat_q == 0) is not yet driven.
  assign C2_oe  = (state_q != ST_IDLE) && (lat_q != '0);
  assign resp   = (C2_oe && ((state_q == ST_RD_BURST) || (state_q == ST_RESP))) ? RESPONSE
                                                                                  : BUSY;
  assign C2_out = {1'b0, resp};
  assign D2_oe  = (state_q == ST_RD_BURST);
  assign D2_out = D2_oe ? mem_rdata : '0;
  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: doc/mem_ctr_param.md
Name: mem_ctr_param

Overview:
- Parametrised next-generation main-memory controller model on the cache-to-memory bus (bus 2), sitting below the cache controller.
- Serves whole-line READ_LINE and WRITE_LINE transactions with configurable line size, data width, depth and latencies.
- Replaces the bidirectional D2/C2 wires with split in/out/output-enable ports so the top level owns the tristate.
- Adds protocol-error detection, transaction counters and clean async-reset abort.

Parameters:
- DATA_W, 16, data-bus width in bits; multiple of 8.
- LINE_BYTES, 16, cache line size in bytes; multiple of DATA_W/8.
- MEM_BYTES, 262144, memory size in bytes; power of two.
- ADDR_W, 14, line-address width; equals log2(MEM_BYTES/LINE_BYTES).
- READ_LAT, 100, cycles from command-sample edge to first read beat; minimum 2.
- WRITE_LAT, 100, cycles from command-sample edge to write response; minimum BURST+1.
- CNT_W, 16, width of statistics counters.
- Derived, not overridable: BURST = LINE_BYTES*8/DATA_W (default 8).

Ports:
- CLK  in  1  clock; all sampling and driving happen on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- A2  in  ADDR_W  line address; sampled with the command.
- D2_in  in  DATA_W  write data from the cache.
- D2_out  out  DATA_W  read data to the cache.
- D2_oe  out  1  D2_out drive enable.
- C2_in  in  2  command: 0 NOP, 2 READ_LINE, 3 WRITE_LINE; 1 is reserved and treated as NOP.
- C2_out  out  2  response: 0 BUSY, 1 RESPONSE.
- C2_oe  out  1  C2_out drive enable.
- err  out  1  sticky protocol error.
- rd_cnt  out  CNT_W  completed reads.
- wr_cnt  out  CNT_W  completed writes.

Behaviour:
- Reset values (RESET low, asynchronous): D2_oe=0, C2_oe=0, D2_out=0, C2_out=0, err=0, rd_cnt=0, wr_cnt=0, FSM=IDLE.
- Reset does not clear memory contents. Memory is zero-initialised at time 0.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, RESP.
- IDLE:
  - Samples C2_in at each edge t.
  - READ_LINE: latch A2; go to RD_WAIT.
  - WRITE_LINE: latch A2; write beat 0 (D2_in) to word 0 of the line; go to WR_BURST.
- Read timing:
  - After edge t+1: C2_oe=1, C2_out=BUSY.
  - After edge t+READ_LAT+k, for k=0..BURST-1: C2_out=RESPONSE, D2_oe=1, D2_out=word k of the line.
  - Word k holds byte 2k+1 in bits[15:8] and byte 2k in bits[7:0] (little-endian generally).
  - After edge t+READ_LAT+BURST: both enables drop; rd_cnt increments; FSM returns to IDLE. Next command can be sampled at that same edge+1.
- Write timing:
  - Beat k is sampled from D2_in at edge t+k, k=0..BURST-1, into word k.
  - From edge t+1: C2_oe=1, C2_out=BUSY.
  - After edge t+WRITE_LAT: C2_out=RESPONSE for exactly one cycle (RESP state).
  - Enables then drop; wr_cnt increments.
- Line address bits are A2; word offset is the beat index, no wrap-around. Byte address = A2*LINE_BYTES + k*DATA_W/8.
- Any nonzero, non-reserved C2_in sampled while not in IDLE is a protocol error:
  - Sets err, which stays set until reset.
  - The command is ignored and the current transaction continues unaffected.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Reset mid-transaction:
  - Enables drop immediately; FSM goes to IDLE.
  - Write beats already sampled remain in memory; unsampled beats are not written.
  - Counters are not incremented for the aborted transaction.
- A read issued right after a write to the same line returns the new data.

Decomposition:
- Package mem_ctr_pkg holds:
  - cmd_e (NOP=0, RSVD=1, READ_LINE=2, WRITE_LINE=3)
  - resp_e (BUSY=0, RESPONSE=1)
  - state_e
  - the latency-legality constant function used by elaboration assertions.
- Sub-module mem_ctr_array: word-organised RAM with depth MEM_BYTES/(DATA_W/8), one synchronous write port and one asynchronous read port.
- mem_ctr_param contains the FSM, beat counter, latency counter, error and statistics logic.

Test Plan:
- Defaults: WRITE_LINE to A2=0x0005 with beats 0x1100..0x1107 → BUSY from cycle 1; RESPONSE exactly at cycle 100 for one cycle; wr_cnt=1; C2_oe=0 at cycle 101.
- Then READ_LINE to A2=0x0005 → C2_out=BUSY for cycles 1–99; beats 0x1100..0x1107 with RESPONSE at cycles 100–107; D2_oe drops at 108; rd_cnt=1.
- DATA_W=32, LINE_BYTES=32, READ_LAT=4: read of a freshly written line → BURST=8, first beat at cycle 4, byte ordering little-endian.
- WRITE_LINE issued during a read burst → err=1; read data unchanged; rd_cnt=1; wr_cnt=0.
- RESET low at write beat 3 → enables drop the same cycle; a later read shows beats 0–3 new and beats 4–7 at their old values; wr_cnt=0.
- CNT_W=2: five reads → rd_cnt saturates at 3.
